// File: rtl/icache_pkg.sv
// Shared I-cache definitions: update-port op encodings, derived address-field
// widths and the miss-controller state/drop enums.
package icache_pkg;

  localparam logic [2:0] OP_RD   = 3'b001;
  localparam logic [2:0] OP_FILL = 3'b010;
  localparam logic [2:0] OP_INV  = 3'b100;

  function automatic int off_w(input int cache_line);
    return $clog2(cache_line);
  endfunction

  function automatic int idx_w(input int set_cnt);
    return $clog2(set_cnt);
  endfunction

  function automatic int tag_w(input int addr_sz, input int set_cnt, input int cache_line);
    return addr_sz - $clog2(set_cnt) - $clog2(cache_line);
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_REPLAY
  } miss_state_t;

  // Flush and refetch drops resolve differently when the response lands.
  typedef enum logic [1:0] {
    DROP_NONE,
    DROP_FLUSH,
    DROP_REFETCH
  } drop_t;

endpackage

// File: rtl/imiss_ctrl_if.sv
// I-cache update port: one op per accepted cycle toward the tag/data arrays.
interface imiss_ctrl_if #(
  parameter int IDX_W  = 10,
  parameter int TAG_W  = 13,
  parameter int LINE_W = 512
) ();
  logic              valid;
  logic              ready;
  logic [2:0]        op;
  logic              is_l2_req;
  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag_addr;
  logic [LINE_W-1:0] data;

  modport master (output valid, op, is_l2_req, index, tag_addr, data, input ready);
  modport slave  (input valid, op, is_l2_req, index, tag_addr, data, output ready);
endinterface

// File: rtl/iupd_arb.sv
// Two-source update-port mux: a pending fill owns the port; otherwise an
// invalidate passes straight through in the cycle it is accepted.
module iupd_arb
  import icache_pkg::*;
#(
  parameter int IDX_W  = 10,
  parameter int TAG_W  = 13,
  parameter int LINE_W = 512
) (
  input  logic              fill_valid,
  input  logic [IDX_W-1:0]  fill_index,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_data,
  input  logic              inval_valid,
  input  logic [IDX_W-1:0]  inval_index,
  input  logic [TAG_W-1:0]  inval_tag,
  output logic              inval_ready,
  imiss_ctrl_if.master      upd
);

  assign inval_ready = inval_valid && upd.ready && !fill_valid;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    upd.valid     = 1'b0;
    upd.op        = 3'b000;
    upd.is_l2_req = 1'b0;
    upd.index     = '0;
    upd.tag_addr  = '0;
    upd.data      = '0;
    if (fill_valid) begin
      upd.valid     = 1'b1;
      upd.op        = OP_FILL;
      upd.is_l2_req = 1'b1;
      upd.index     = fill_index;
      upd.tag_addr  = fill_tag;
      upd.data      = fill_data;
    end else if (inval_ready) begin
      upd.valid     = 1'b1;
      upd.op        = OP_INV;
      upd.is_l2_req = 1'b1;
      upd.index     = inval_index;
      upd.tag_addr  = inval_tag;
    end
  end

endmodule

// File: rtl/imiss_ctrl.sv
// Single-outstanding I-cache miss controller: L2 line request, fill through the
// shared update port, replay to F2, and the front-end miss stall.
module imiss_ctrl
  import icache_pkg::*;
#(
  parameter int SET_CNT    = 1024,
  parameter int CACHE_LINE = 512,
  parameter int ADDR_SZ    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  input  logic [ADDR_SZ-1:0]    miss_addr,
  input  logic                  flush,
  output logic                  l2_req_valid,
  input  logic                  l2_req_ready,
  output logic [ADDR_SZ-1:0]    l2_req_addr,
  input  logic                  l2_resp_valid,
  input  logic [CACHE_LINE-1:0] l2_resp_data,
  input  logic                  inval_valid,
  input  logic [ADDR_SZ-1:0]    inval_addr,
  output logic                  inval_ready,
  imiss_ctrl_if.master          upd,
  output logic                  stall,
  output logic                  replay_valid,
  output logic [ADDR_SZ-1:0]    replay_addr
);

  localparam int OFF_W = off_w(CACHE_LINE);
  localparam int IDX_W = idx_w(SET_CNT);
  localparam int TAG_W = tag_w(ADDR_SZ, SET_CNT, CACHE_LINE);
  localparam int LA_W  = TAG_W + IDX_W;

  miss_state_t           state;
  drop_t                 drop;
  logic [LA_W-1:0]       pend_la;
  logic [ADDR_SZ-1:0]    pend_addr;
  logic [CACHE_LINE-1:0] line_buf;
  logic                  inval_hit;

  assign inval_hit = inval_ready && (inval_addr[ADDR_SZ-1:OFF_W] == pend_la);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drop      <= DROP_NONE;
      pend_la   <= '0;
      pend_addr <= '0;
      // NOTE: the line buffer is a plain register bank, so clearing it on reset is cheap and intended.
      line_buf  <= '0;
    end else begin
      case (state)
        S_IDLE: if (miss_valid && !flush) begin
          pend_addr <= miss_addr;
          pend_la   <= miss_addr[ADDR_SZ-1:OFF_W];
          drop      <= DROP_NONE;
          state     <= S_REQ;
        end
        S_REQ: begin
          if (l2_req_ready) begin
            drop  <= flush ? DROP_FLUSH : DROP_NONE;
            state <= S_WAIT;
          end else if (flush) begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          // A flush kills the miss outright and beats any pending refetch.
          if (flush || drop == DROP_FLUSH) begin
            drop <= l2_resp_valid ? DROP_NONE : DROP_FLUSH;
            if (l2_resp_valid) state <= S_IDLE;
          end else if (inval_hit || drop == DROP_REFETCH) begin
            drop <= l2_resp_valid ? DROP_NONE : DROP_REFETCH;
            if (l2_resp_valid) state <= S_REQ;
          end else if (l2_resp_valid) begin
            line_buf <= l2_resp_data;
            state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (flush) drop <= DROP_FLUSH;
          if (upd.ready) begin
            drop  <= DROP_NONE;
            state <= (flush || drop == DROP_FLUSH) ? S_IDLE : S_REPLAY;
          end
        end
        S_REPLAY: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign stall        = (state != S_IDLE) || (miss_valid && !flush);
  assign l2_req_valid = (state == S_REQ);
  assign l2_req_addr  = {pend_la, {OFF_W{1'b0}}};
  assign replay_valid = (state == S_REPLAY) && !flush;
  assign replay_addr  = pend_addr;

  iupd_arb #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .LINE_W(CACHE_LINE)
  ) u_arb (
    .fill_valid (state == S_FILL),
    .fill_index (pend_la[IDX_W-1:0]),
    .fill_tag   (pend_la[LA_W-1:IDX_W]),
    .fill_data  (line_buf),
    .inval_valid(inval_valid),
    .inval_index(inval_addr[OFF_W+IDX_W-1:OFF_W]),
    .inval_tag  (inval_addr[ADDR_SZ-1:OFF_W+IDX_W]),
    .inval_ready(inval_ready),
    .upd        (upd)
  );

endmodule

// File: tb/tb_imiss_ctrl.sv
// Directed bench for imiss_ctrl: IDLE-state vector table plus multi-cycle
// sequences for miss, flush, refetch, port contention and reset.
module tb_imiss_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         flush;
  logic         l2_req_valid;
  logic         l2_req_ready;
  logic [31:0]  l2_req_addr;
  logic         l2_resp_valid;
  logic [511:0] l2_resp_data;
  logic         inval_valid;
  logic [31:0]  inval_addr;
  logic         inval_ready;
  logic         stall;
  logic         replay_valid;
  logic [31:0]  replay_addr;

  imiss_ctrl_if #(.IDX_W(10), .TAG_W(13), .LINE_W(512)) upd ();

  imiss_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .miss_valid   (miss_valid),
    .miss_addr    (miss_addr),
    .flush        (flush),
    .l2_req_valid (l2_req_valid),
    .l2_req_ready (l2_req_ready),
    .l2_req_addr  (l2_req_addr),
    .l2_resp_valid(l2_resp_valid),
    .l2_resp_data (l2_resp_data),
    .inval_valid  (inval_valid),
    .inval_addr   (inval_addr),
    .inval_ready  (inval_ready),
    .upd          (upd),
    .stall        (stall),
    .replay_valid (replay_valid),
    .replay_addr  (replay_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act[63:0], exp[63:0]);
    end
  endtask

  // Event monitor: counts committed transfers, sampled on the falling edge.
  int           n_req = 0, n_fill = 0, n_inv = 0, n_rep = 0, n_stall = 0;
  logic [31:0]  last_req = '0, last_rep = '0;
  logic [9:0]   f_idx = '0;
  logic [12:0]  f_tag = '0;
  logic [511:0] f_data = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (l2_req_valid && l2_req_ready) begin n_req++; last_req = l2_req_addr; end
      if (upd.valid && upd.ready) begin
        if (upd.op == 3'b010) begin
          n_fill++; f_idx = upd.index; f_tag = upd.tag_addr; f_data = upd.data;
        end else if (upd.op == 3'b100) begin
          n_inv++;
        end
      end
      if (replay_valid) begin n_rep++; last_rep = replay_addr; end
      if (stall) n_stall++;
    end
  end

  int b_req, b_fill, b_inv, b_rep, b_stall;

  task automatic snap();
    b_req = n_req; b_fill = n_fill; b_inv = n_inv; b_rep = n_rep; b_stall = n_stall;
  endtask

  task automatic idle_inputs();
    miss_valid = 0; miss_addr = '0; flush = 0; l2_req_ready = 0;
    l2_resp_valid = 0; l2_resp_data = '0; inval_valid = 0; inval_addr = '0;
    upd.ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        miss_valid;
    logic        flush;
    logic        inval_valid;
    logic [31:0] inval_addr;
    logic        upd_ready;
    logic        stall;
    logic        inval_ready;
    logic        upd_valid;
    logic [2:0]  op;
    logic [9:0]  idx;
    logic [12:0] tag;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 10'h000, 13'h0000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 10'h000, 13'h0000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 10'h000, 13'h0000};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0001_2200, 1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 10'h091, 13'h0000};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0001_2200, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 10'h000, 13'h0000};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FE00, 1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 10'h3FF, 13'h1FFF};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h8008_0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 10'h000, 13'h1001};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h8008_0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 10'h000, 13'h0000};

    do_reset();
    check("reset_outputs",
          {l2_req_valid, l2_req_addr, inval_ready, upd.valid, upd.op, upd.index, upd.tag_addr, stall, replay_valid},
          '0);
    check("reset_replay_addr", replay_addr, 32'h0);

    // IDLE-state combinational vectors; inputs cleared before each edge.
    for (int i = 0; i < 8; i++) begin
      tick();
      miss_valid = vecs[i].miss_valid; flush = vecs[i].flush;
      inval_valid = vecs[i].inval_valid; inval_addr = vecs[i].inval_addr;
      upd.ready = vecs[i].upd_ready;
      #1;
      check($sformatf("vec%0d", i),
            {stall, inval_ready, upd.valid, upd.is_l2_req, upd.op, upd.index, upd.tag_addr},
            {vecs[i].stall, vecs[i].inval_ready, vecs[i].upd_valid, vecs[i].upd_valid,
             vecs[i].op, vecs[i].idx, vecs[i].tag});
      check_line($sformatf("vec%0d_data", i), upd.data, '0);
      #1 idle_inputs();
    end

    // Basic miss.
    do_reset();
    tick();
    snap();
    miss_valid = 1; miss_addr = 32'h0001_2345; l2_req_ready = 1; upd.ready = 1;
    #1 check("basic_stall_zero_latency", stall, 1);
    tick();
    miss_valid = 0;
    check("basic_req_valid", l2_req_valid, 1);
    check("basic_req_addr", l2_req_addr, 32'h0001_2200);
    repeat (5) @(posedge clk);
    #1 l2_resp_valid = 1; l2_resp_data = {64{8'hA5}};
    tick();
    l2_resp_valid = 0;
    check("basic_fill_op", {upd.valid, upd.is_l2_req, upd.op}, {1'b1, 1'b1, 3'b010});
    repeat (6) @(posedge clk);
    #1;
    check("basic_reqs", n_req - b_req, 1);
    check("basic_fills", n_fill - b_fill, 1);
    check("basic_fill_idx_tag", {f_idx, f_tag}, {10'h091, 13'h0000});
    check_line("basic_fill_data", f_data, {64{8'hA5}});
    check("basic_replays", n_rep - b_rep, 1);
    check("basic_replay_addr", last_rep, 32'h0001_2345);
    check("basic_stall_cycles", n_stall - b_stall, 9);
    check("basic_idle_after", stall, 0);

    // Flush one cycle after the request handshake.
    do_reset();
    tick();
    snap();
    miss_valid = 1; miss_addr = 32'h0000_4000; l2_req_ready = 1; upd.ready = 1;
    tick();
    miss_valid = 0;
    tick();
    flush = 1;
    tick();
    flush = 0;
    tick();
    tick();
    l2_resp_valid = 1; l2_resp_data = {64{8'h77}};
    tick();
    l2_resp_valid = 0;
    check("wflush_idle", stall, 0);
    check("wflush_no_fill", n_fill - b_fill, 0);
    check("wflush_no_replay", n_rep - b_rep, 0);
    miss_valid = 1; miss_addr = 32'h0000_8040;
    #1 check("wflush_new_miss_stall", stall, 1);
    tick();
    miss_valid = 0;
    check("wflush_new_req", {l2_req_valid, l2_req_addr}, {1'b1, 32'h0000_8000});
    tick();
    check("wflush_total_reqs", n_req - b_req, 2);

    // Flush in REQ while L2 is not ready.
    do_reset();
    tick();
    snap();
    miss_valid = 1; miss_addr = 32'h0000_1000;
    tick();
    miss_valid = 0;
    check("rflush_req_valid", l2_req_valid, 1);
    flush = 1;
    tick();
    flush = 0; l2_req_ready = 1;
    check("rflush_idle", {l2_req_valid, stall}, 2'b00);
    repeat (3) tick();
    check("rflush_no_handshake", n_req - b_req, 0);

    // Invalidate hits the pending line in WAIT: response dropped, line refetched.
    do_reset();
    tick();
    snap();
    miss_valid = 1; miss_addr = 32'h0001_2345; l2_req_ready = 1; upd.ready = 1;
    tick();
    miss_valid = 0;
    tick();
    inval_valid = 1; inval_addr = 32'h0001_2200;
    #1 check("rinv_issue", {inval_ready, upd.valid, upd.op, upd.index, upd.tag_addr},
             {1'b1, 1'b1, 3'b100, 10'h091, 13'h0000});
    tick();
    inval_valid = 0;
    tick();
    l2_resp_valid = 1; l2_resp_data = {64{8'h11}};
    tick();
    l2_resp_valid = 0;
    check("rinv_rerequest", {l2_req_valid, l2_req_addr}, {1'b1, 32'h0001_2200});
    tick();
    tick();
    l2_resp_valid = 1; l2_resp_data = {64{8'h3C}};
    tick();
    l2_resp_valid = 0;
    repeat (4) tick();
    check("rinv_reqs", n_req - b_req, 2);
    check("rinv_last_req", last_req, 32'h0001_2200);
    check("rinv_invs", n_inv - b_inv, 1);
    check("rinv_fills", n_fill - b_fill, 1);
    check_line("rinv_fill_data", f_data, {64{8'h3C}});
    check("rinv_replay", {n_rep - b_rep, last_rep}, {32'd1, 32'h0001_2345});

    // Port contention: invalidate waits behind a held fill.
    do_reset();
    tick();
    snap();
    miss_valid = 1; miss_addr = 32'h0004_0A00; l2_req_ready = 1;
    tick();
    miss_valid = 0;
    tick();
    l2_resp_valid = 1; l2_resp_data = {64{8'h5A}};
    tick();
    l2_resp_valid = 0; inval_valid = 1; inval_addr = 32'h0000_0600; upd.ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("cont_hold%0d", i),
               {upd.valid, upd.op, upd.index, inval_ready}, {1'b1, 3'b010, 10'h205, 1'b0});
      check_line($sformatf("cont_hold%0d_data", i), upd.data, {64{8'h5A}});
      tick();
    end
    upd.ready = 1;
    #1 check("cont_fill_commit", {upd.op, inval_ready}, {3'b010, 1'b0});
    tick();
    #1 check("cont_inv_next", {inval_ready, upd.valid, upd.op, upd.index},
             {1'b1, 1'b1, 3'b100, 10'h003});
    tick();
    inval_valid = 0;
    repeat (2) tick();
    check("cont_fill_once", {n_fill - b_fill, 22'(f_idx)}, {32'd1, 22'h205});
    check("cont_inv_once", n_inv - b_inv, 1);
    check("cont_replay", n_rep - b_rep, 1);

    // Reset while waiting for L2, then a late response.
    do_reset();
    tick();
    snap();
    miss_valid = 1; miss_addr = 32'h0001_2345; l2_req_ready = 1; upd.ready = 1;
    tick();
    miss_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("rst_wait_outputs",
          {l2_req_valid, l2_req_addr, inval_ready, upd.valid, upd.op, stall, replay_valid, replay_addr},
          '0);
    tick();
    l2_resp_valid = 1; l2_resp_data = {64{8'hEE}};
    tick();
    l2_resp_valid = 0;
    check_line("rst_late_resp_data", upd.data, '0);
    repeat (3) tick();
    check("rst_late_no_fill", n_fill - b_fill, 0);
    check("rst_late_no_replay", n_rep - b_rep, 0);
    check("rst_late_idle", {stall, upd.valid, l2_req_valid}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imiss_ctrl.md
Name: imiss_ctrl

Overview:
- Single-outstanding I-cache miss controller and update-port arbiter, sitting beside the F2 update path.
- Accepts F2 misses, issues one line request to L2, captures the response, and drives the fill (op 3'b010, is_l2_req=1) into the update port.
- Shares that port with L2 back-invalidates (op 3'b100, is_l2_req=1), then signals a replay to F2.
- Owns the front-end miss stall.

Parameters:
SET_CNT, 1024, sets per way
CACHE_LINE, 512, line size in bits; offset width = $clog2(CACHE_LINE)
ADDR_SZ, 32, address width
(derived) IDX_W = $clog2(SET_CNT); OFF_W = $clog2(CACHE_LINE); TAG_W = ADDR_SZ-IDX_W-OFF_W; LA_W = TAG_W+IDX_W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
miss_valid  in  1  F2 miss (op 001 with hit=0)
miss_addr  in  ADDR_SZ  missing fetch address
flush  in  1  redirect; kill in-flight miss
l2_req_valid  out  1  line request to L2
l2_req_ready  in  1  L2 accepts request
l2_req_addr  out  ADDR_SZ  line-aligned address (offset bits zero)
l2_resp_valid  in  1  line data returned
l2_resp_data  in  CACHE_LINE  line data
inval_valid  in  1  L2 back-invalidate request
inval_addr  in  ADDR_SZ  address to invalidate
inval_ready  out  1  invalidate accepted this cycle
upd_valid  out  1  update-port op valid
upd_ready  in  1  update path can accept (its !stall)
upd_op  out  3  3'b010 fill / 3'b100 invalidate
upd_is_l2_req  out  1  always 1 when upd_valid
upd_index  out  IDX_W  set index
upd_tag_addr  out  TAG_W  tag
upd_data  out  CACHE_LINE  fill data (0 for invalidate)
stall  out  1  front-end miss stall
replay_valid  out  1  one-cycle pulse: re-fetch replay_addr
replay_addr  out  ADDR_SZ  original miss address

Behaviour:
- Reset: state IDLE; drop=0; all outputs 0; line and data buffers cleared. Reset mid-miss abandons it with no fill and no replay. An L2 response arriving after reset is ignored (IDLE ignores l2_resp_valid).
- Registers: pend_la[LA_W], pend_addr[ADDR_SZ], line_buf[CACHE_LINE], drop.
- States: IDLE, REQ, WAIT, FILL, REPLAY.
- stall = (state != IDLE) || (state==IDLE && miss_valid && !flush). Combinational, zero-latency on miss.
- IDLE:
  - miss_valid && !flush: latch pend_addr=miss_addr and pend_la=miss_addr[ADDR_SZ-1:OFF_W]; go to REQ.
  - A miss with flush in the same cycle is ignored.
- REQ:
  - l2_req_valid=1; l2_req_addr={pend_la, OFF_W'b0}, held stable until handshake.
  - flush && !l2_req_ready: go to IDLE, nothing issued.
  - l2_req_ready: go to WAIT with drop=flush.
- WAIT:
  - flush sets drop.
  - Invalidate accepted to an address whose line matches pend_la sets drop=refetch; the refetch flag is kept distinct from the flush flag.
  - On l2_resp_valid:
    - flush-drop: go to IDLE.
    - refetch-drop: clear drop, go to REQ.
    - otherwise: line_buf=l2_resp_data, go to FILL.
  - No timeout.
- FILL:
  - upd_valid=1, op 010, index/tag from pend_la, data=line_buf.
  - Hold all fields until upd_ready.
  - On upd_ready go to REPLAY, or go to IDLE if flush was seen during FILL (the fill still commits).
- REPLAY: replay_valid=1 with replay_addr=pend_addr for exactly one cycle; go to IDLE. flush in this cycle suppresses replay_valid.
- Arbitration of the update port:
  - Invalidate owns the port in every state except FILL.
  - inval_ready = inval_valid && upd_ready && state!=FILL.
  - When accepted, the invalidate drives upd_valid=1, op 100, index/tag from inval_addr, data=0, in the same cycle (combinational pass-through).
  - In FILL, inval_ready=0, so the invalidate waits at most until fill completion.
- Simultaneous events:
  - l2_resp_valid together with a matching invalidate in WAIT: refetch wins (go to REQ).
  - miss_valid in non-IDLE states is ignored; F2 is stalled.
- upd_valid is never asserted for two sources in one cycle.

Decomposition:
- Shared package icache_pkg:
  - op encodings OP_RD=3'b001, OP_FILL=3'b010, OP_INV=3'b100.
  - derived-width functions (IDX_W/TAG_W/OFF_W from SET_CNT, CACHE_LINE, ADDR_SZ).
  - state enum.
- One natural sub-module: iupd_arb, the two-source update-port mux/arbiter (fill vs invalidate, ready generation). The FSM stays in imiss_ctrl.

Test Plan:
- Basic miss: miss_addr=0x0001_2345, l2_req_ready immediate, resp 5 cycles later with data=A5 pattern, upd_ready=1.
  - Expect l2_req_addr=0x0001_2200.
  - Expect one upd_valid with op 010, index=0x091, tag=0x0.
  - Expect a replay_valid pulse with 0x0001_2345.
  - Expect stall high from the miss cycle through REPLAY.
- Flush in WAIT: flush one cycle after the request handshake.
  - Response arrives, then no upd_valid and no replay; state is IDLE the next cycle.
  - A new miss is accepted immediately.
- Flush in REQ with l2_req_ready=0: return to IDLE with zero l2 handshakes.
- Invalidate matching the pending line in WAIT: inval_addr=0x0001_2200.
  - Expect op 100 upd issued immediately.
  - The response is discarded and a second l2_req to 0x0001_2200 follows, then fill and replay.
- Port contention: inval_valid asserted during FILL with upd_ready low for 3 cycles.
  - Fill holds stable and commits first.
  - inval_ready stays 0 until state leaves FILL; the invalidate is issued the next cycle.
- Reset in WAIT, then a late l2_resp_valid: no upd_valid, no replay, all outputs 0.
